// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the data-memory arbiter and the
// single-port data memory.
interface dmem_arbiter_if #(
  parameter int BEATS_W = 2
);
  logic               m0_req,    m1_req;
  logic               m0_we,     m1_we;
  logic [31:0]        m0_addr,   m1_addr;
  logic [BEATS_W-1:0] m0_len,    m1_len;
  logic [31:0]        m0_wdata,  m1_wdata;
  logic               m0_gnt,    m1_gnt;
  logic               m0_ack,    m1_ack;
  logic               m0_rvalid, m1_rvalid;
  logic               m0_done,   m1_done;
  logic [31:0]        rdata;
  logic               mem_we;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_wd;
  logic [31:0]        mem_rd;

  // Requester/memory view: drives requests and memory read data.
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_len, m1_len, m0_wdata, m1_wdata, mem_rd,
    input  m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rvalid, m1_rvalid,
           m0_done, m1_done, rdata, mem_we, mem_addr, mem_wd
  );

  // Arbiter view.
  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_len, m1_len, m0_wdata, m1_wdata, mem_rd,
    output m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rvalid, m1_rvalid,
           m0_done, m1_done, rdata, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master round-robin burst arbiter for the single-port data memory.
// Grants one burst of 1..4 consecutive words at a time and sequences it.
module dmem_arbiter #(
  parameter int BEATS_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e             state_q,      state_d;
  logic               last_owner_q, last_owner_d;
  logic               owner_q,      owner_d;
  logic               we_q,         we_d;
  logic [31:0]        addr_q,       addr_d;
  logic [BEATS_W-1:0] len_q,        len_d;
  logic [BEATS_W-1:0] beat_cnt_q,   beat_cnt_d;
  logic [1:0]         rvalid_q,     rvalid_d;
  logic [1:0]         done_q,       done_d;
  logic [31:0]        rdata_q,      rdata_d;

  logic        winner;
  logic        in_burst;
  logic [31:0] beat_offset;

  // On a tie the master that did not own the previous burst wins.
  assign winner      = (bus.m0_req && bus.m1_req) ? ~last_owner_q : bus.m1_req;
  assign in_burst    = (state_q == BURST);
  assign beat_offset = {{(30-BEATS_W){1'b0}}, beat_cnt_q, 2'b00};

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    rvalid_d     = 2'b00;
    done_d       = 2'b00;
    rdata_d      = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d      = BURST;
          owner_d      = winner;
          last_owner_d = winner;
          we_d         = winner ? bus.m1_we   : bus.m0_we;
          addr_d       = winner ? bus.m1_addr : bus.m0_addr;
          len_d        = winner ? bus.m1_len  : bus.m0_len;
          beat_cnt_d   = '0;
        end
      end
      BURST: begin
        if (!we_q) begin
          rdata_d           = bus.mem_rd;
          rvalid_d[owner_q] = 1'b1;
        end
        if (beat_cnt_q == len_q) begin
          state_d         = IDLE;
          done_d[owner_q] = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      rvalid_q     <= 2'b00;
      done_q       <= 2'b00;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      rvalid_q     <= rvalid_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
    end
  end

  // Memory side is forced to zero outside a burst so no stray write can occur.
  assign bus.mem_we   = in_burst && we_q;
  assign bus.mem_addr = in_burst ? (addr_q + beat_offset) : 32'h0;
  assign bus.mem_wd   = !in_burst ? 32'h0 : (owner_q ? bus.m1_wdata : bus.m0_wdata);

  assign bus.m0_gnt    = in_burst && !owner_q;
  assign bus.m1_gnt    = in_burst &&  owner_q;
  assign bus.m0_ack    = bus.m0_gnt;
  assign bus.m1_ack    = bus.m1_gnt;
  assign bus.m0_rvalid = rvalid_q[0];
  assign bus.m1_rvalid = rvalid_q[1];
  assign bus.m0_done   = done_q[0];
  assign bus.m1_done   = done_q[1];
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word-addressed
// memory model behind the arbiter.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [0:63];

  dmem_arbiter_if #(.BEATS_W(2)) bus ();

  dmem_arbiter #(.BEATS_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mem_rd = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) mem[bus.mem_addr[7:2]] <= bus.mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [1:0] len, input logic [31:0] wdata);
    bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr;
    bus.m0_len = len; bus.m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [1:0] len, input logic [31:0] wdata);
    bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr;
    bus.m1_len = len; bus.m1_wdata = wdata;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;

    // Reset with both masters requesting a 1-beat read.
    rst = 1'b1;
    drive_m0(1'b1, 1'b0, 32'h0, 2'd0, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h40, 2'd0, 32'h0);
    tick();
    tick();
    check("rst_gnt",    {30'h0, bus.m1_gnt, bus.m0_gnt}, 32'h0);
    check("rst_ack",    {30'h0, bus.m1_ack, bus.m0_ack}, 32'h0);
    check("rst_rvalid", {30'h0, bus.m1_rvalid, bus.m0_rvalid}, 32'h0);
    check("rst_done",   {30'h0, bus.m1_done, bus.m0_done}, 32'h0);
    check("rst_rdata",  bus.rdata, 32'h0);
    check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wd", bus.mem_wd, 32'h0);

    rst = 1'b0;
    #1;
    check("idle_after_rst_gnt", {30'h0, bus.m1_gnt, bus.m0_gnt}, 32'h0);
    tick();
    check("first_tie_gnt", {30'h0, bus.m1_gnt, bus.m0_gnt}, 32'h1);
    check("first_tie_ack", {30'h0, bus.m1_ack, bus.m0_ack}, 32'h1);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    tick();
    check("first_done",   {30'h0, bus.m1_done, bus.m0_done}, 32'h1);
    check("first_rvalid", {30'h0, bus.m1_rvalid, bus.m0_rvalid}, 32'h1);
    check("first_rdata",  bus.rdata, 32'hA000_0000);
    tick();

    // m1 single write of 0x10, then read it back.
    drive_m1(1'b1, 1'b1, 32'h10, 2'd0, 32'hDEAD_BEEF);
    tick();
    bus.m1_req = 1'b0;
    #1;
    check("m1_wr_gnt",      {30'h0, bus.m1_gnt, bus.m0_gnt}, 32'h2);
    check("m1_wr_ack",      {30'h0, bus.m1_ack, bus.m0_ack}, 32'h2);
    check("m1_wr_mem_we",   {31'h0, bus.mem_we}, 32'h1);
    check("m1_wr_mem_addr", bus.mem_addr, 32'h10);
    check("m1_wr_mem_wd",   bus.mem_wd, 32'hDEAD_BEEF);
    tick();
    check("m1_wr_done",   {30'h0, bus.m1_done, bus.m0_done}, 32'h2);
    check("m1_wr_rvalid", {30'h0, bus.m1_rvalid, bus.m0_rvalid}, 32'h0);
    check("m1_wr_we_off", {31'h0, bus.mem_we}, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h10, 2'd0, 32'h0);
    tick();
    bus.m1_req = 1'b0;
    check("m1_rd_mem_addr", bus.mem_addr, 32'h10);
    check("m1_rd_mem_we",   {31'h0, bus.mem_we}, 32'h0);
    tick();
    check("m1_rd_rvalid", {30'h0, bus.m1_rvalid, bus.m0_rvalid}, 32'h2);
    check("m1_rd_rdata",  bus.rdata, 32'hDEAD_BEEF);
    check("m1_rd_done",   {30'h0, bus.m1_done, bus.m0_done}, 32'h2);

    // m0 4-beat read from 0x20 (words 8..11).
    drive_m0(1'b1, 1'b0, 32'h20, 2'd3, 32'h0);
    tick();
    bus.m0_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("m0_burst_addr", bus.mem_addr, 32'h20 + 32'(4 * i));
      check("m0_burst_gnt",  {30'h0, bus.m1_gnt, bus.m0_gnt}, 32'h1);
      check("m0_burst_done", {30'h0, bus.m1_done, bus.m0_done}, 32'h0);
      if (i > 0) begin
        check("m0_burst_rvalid", {30'h0, bus.m1_rvalid, bus.m0_rvalid}, 32'h1);
        check("m0_burst_rdata",  bus.rdata, 32'hA000_0008 + 32'(i - 1));
      end
      tick();
    end
    check("m0_burst_last_rvalid", {30'h0, bus.m1_rvalid, bus.m0_rvalid}, 32'h1);
    check("m0_burst_last_rdata",  bus.rdata, 32'hA000_000B);
    check("m0_burst_end_done",    {30'h0, bus.m1_done, bus.m0_done}, 32'h1);
    check("m0_burst_end_gnt",     {30'h0, bus.m1_gnt, bus.m0_gnt}, 32'h0);

    // Round-robin: m0 owned last, so m1 wins first, then they alternate.
    drive_m0(1'b1, 1'b0, 32'h0, 2'd1, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h40, 2'd1, 32'h0);
    for (int g = 0; g < 4; g++) begin
      logic [31:0] exp_sel;
      exp_sel = (g % 2 == 0) ? 32'h2 : 32'h1;
      tick();
      check("rr_beat1_gnt", {30'h0, bus.m1_gnt, bus.m0_gnt}, exp_sel);
      check("rr_beat1_ack", {30'h0, bus.m1_ack, bus.m0_ack}, exp_sel);
      tick();
      check("rr_beat2_ack", {30'h0, bus.m1_ack, bus.m0_ack}, exp_sel);
      tick();
      check("rr_idle_gnt",  {30'h0, bus.m1_gnt, bus.m0_gnt}, 32'h0);
      check("rr_idle_done", {30'h0, bus.m1_done, bus.m0_done}, exp_sel);
      if (g == 3) begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
      end
    end
    tick();
    check("rr_stop_gnt", {30'h0, bus.m1_gnt, bus.m0_gnt}, 32'h0);

    // Address wrap across 2^32.
    drive_m0(1'b1, 1'b0, 32'hFFFF_FFFC, 2'd1, 32'h0);
    tick();
    bus.m0_req = 1'b0;
    check("wrap_addr0", bus.mem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr1",  bus.mem_addr, 32'h0000_0000);
    check("wrap_rdata0", bus.rdata, 32'hA000_003F);
    tick();
    check("wrap_rdata1", bus.rdata, 32'hA000_0000);
    check("wrap_done",   {30'h0, bus.m1_done, bus.m0_done}, 32'h1);

    // Reset during beat 2 of a 4-beat write at 0x80 (words 32..35).
    drive_m0(1'b1, 1'b1, 32'h80, 2'd3, 32'h1111_1111);
    tick();
    bus.m0_req = 1'b0;
    #1;
    check("mrst_b1_we",   {31'h0, bus.mem_we}, 32'h1);
    check("mrst_b1_addr", bus.mem_addr, 32'h80);
    check("mrst_b1_wd",   bus.mem_wd, 32'h1111_1111);
    tick();
    bus.m0_wdata = 32'h2222_2222;
    rst = 1'b1;
    #1;
    check("mrst_b2_addr", bus.mem_addr, 32'h84);
    check("mrst_b2_wd",   bus.mem_wd, 32'h2222_2222);
    tick();
    rst = 1'b0;
    bus.m0_wdata = 32'h3333_3333;
    check("mrst_after_we",    {31'h0, bus.mem_we}, 32'h0);
    check("mrst_after_gnt",   {30'h0, bus.m1_gnt, bus.m0_gnt}, 32'h0);
    check("mrst_after_done",  {30'h0, bus.m1_done, bus.m0_done}, 32'h0);
    check("mrst_after_rdata", bus.rdata, 32'h0);
    tick();
    check("mrst_idle_done", {30'h0, bus.m1_done, bus.m0_done}, 32'h0);
    check("mrst_idle_we",   {31'h0, bus.mem_we}, 32'h0);
    tick();
    check("mrst_mem32", mem[32], 32'h1111_1111);
    check("mrst_mem33", mem[33], 32'h2222_2222);
    check("mrst_mem34", mem[34], 32'hA000_0022);
    check("mrst_mem35", mem[35], 32'hA000_0023);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
